sample_loader: RTL and testbench

SAMPLE_LOADER -- requirements
Module: sample_loader

---
 rtl/sample_loader_pkg.sv | 26 ++
 rtl/sample_loader_if.sv | 33 +++
 rtl/sample_loader_feature_assembler.sv | 52 +++++
 rtl/sample_loader.sv | 137 +++++++++++++
 tb/tb_sample_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sample_loader_pkg.sv
// Shared widths, limits and state encoding for the sample loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sample_loader_pkg;

   localparam int ADDR_W               = 10;
   localparam int LABEL_W              = 4;
   localparam int BYTE_W               = 8;
   localparam int DEF_BYTES_PER_SAMPLE = 62;
   localparam int FEAT_W               = DEF_BYTES_PER_SAMPLE * BYTE_W;
   localparam int MAX_LABEL            = 9;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FEATURES = 3'd1,
      ST_LABEL    = 3'd2,
      ST_WRITE    = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   // A label byte is legal only when it encodes a class 0..MAX_LABEL
   function automatic logic label_out_of_range(input logic [BYTE_W-1:0] b);
      return (b[7:4] != 4'd0) || (b[3:0] > 4'(MAX_LABEL));
   endfunction

endpackage

// File: rtl/sample_loader_if.sv
// Byte stream in, sample memory write port out, plus run status.
// Latency: none (wiring only).
// Backpressure: in_ready from the loader throttles the byte source.
interface sample_loader_if
   import sample_loader_pkg::*;
#(
   parameter int FW = FEAT_W
)
();
   logic                start;
   logic [BYTE_W-1:0]   in_byte;
   logic                in_valid;
   logic                in_ready;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [FW-1:0]       wr_data;
   logic [LABEL_W-1:0]  wr_label;
   logic                busy;
   logic                load_done;
   logic                label_err;

   // Loader side
   modport slave (
      input  start, in_byte, in_valid,
      output in_ready, wr_en, wr_addr, wr_data, wr_label, busy, load_done, label_err
   );

   // Byte source / memory controller side
   modport master (
      output start, in_byte, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data, wr_label, busy, load_done, label_err
   );
endinterface

// File: rtl/sample_loader_feature_assembler.sv
// Collects one sample's feature bytes into lane-indexed byte slots.
// Latency: a byte lands in its lane on the edge it is loaded.
// Backpressure: none; the caller only pulses load_i on accepted bytes.
module feature_assembler
   import sample_loader_pkg::*;
#(
   parameter int BYTES_PER_SAMPLE = DEF_BYTES_PER_SAMPLE
)
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clear_i,
   input  logic                               load_i,
   input  logic [BYTE_W-1:0]                  byte_i,
   output logic [BYTES_PER_SAMPLE*BYTE_W-1:0] data_o,
   output logic                               last_o
);

   localparam int CNT_W = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_SAMPLE - 1);

   logic [BYTES_PER_SAMPLE-1:0][BYTE_W-1:0] lanes_q;
   logic [CNT_W-1:0]                        byte_cnt_q;
   logic [CNT_W-1:0]                        byte_cnt_d;

   // Lane pointer: restarts on a new run, wraps after the last feature byte
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (clear_i) begin
         byte_cnt_d = '0;
      end else if (load_i) begin
         byte_cnt_d = (byte_cnt_q == LAST_LANE) ? '0 : byte_cnt_q + CNT_W'(1);
      end
   end

   // Lane storage and pointer; lanes only change on an accepted byte
   always_ff @(posedge clk) begin
      if (rst) begin
         lanes_q    <= '0;
         byte_cnt_q <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         if (load_i) begin
            lanes_q[byte_cnt_q] <= byte_i;
         end
      end
   end

   assign data_o = lanes_q;
   assign last_o = (byte_cnt_q == LAST_LANE);

endmodule

// File: rtl/sample_loader.sv
// Loads NUM_SAMPLES (features + label) records from a byte stream into sample memories.
// Latency: write strobe one cycle after the label byte; BYTES_PER_SAMPLE+2 cycles/sample minimum.
// Backpressure: in_ready only in FEATURES/LABEL; in_valid=0 stalls with all state held.
module sample_loader
   import sample_loader_pkg::*;
#(
   parameter int NUM_SAMPLES      = 750,
   parameter int BYTES_PER_SAMPLE = DEF_BYTES_PER_SAMPLE
)
(
   input  logic            clk,
   input  logic            rst,
   sample_loader_if.slave  ld
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    sample_cnt_q, sample_cnt_d;
   logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
   logic [LABEL_W-1:0]   wr_label_q, wr_label_d;
   logic                 label_err_q, label_err_d;
   logic                 load_done_q, load_done_d;
   logic                 in_ready_q;
   logic                 wr_en_q;
   logic                 busy_q;

   logic                 xfer;
   logic                 run_start;
   logic                 feat_load;
   logic                 last_byte;
   logic [BYTES_PER_SAMPLE*BYTE_W-1:0] feat_data;

   assign xfer = ld.in_valid & in_ready_q;

   feature_assembler #(
      .BYTES_PER_SAMPLE (BYTES_PER_SAMPLE)
   ) u_feature_assembler (
      .clk     (clk),
      .rst     (rst),
      .clear_i (run_start),
      .load_i  (feat_load),
      .byte_i  (ld.in_byte),
      .data_o  (feat_data),
      .last_o  (last_byte)
   );

   // Next state, counters and sticky flags; start only honoured when idle or done
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      wr_addr_d    = wr_addr_q;
      wr_label_d   = wr_label_q;
      label_err_d  = label_err_q;
      load_done_d  = load_done_q;
      run_start    = 1'b0;
      feat_load    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (ld.start) begin
               state_d      = ST_FEATURES;
               sample_cnt_d = '0;
               label_err_d  = 1'b0;
               load_done_d  = 1'b0;
               run_start    = 1'b1;
            end
         end
         ST_FEATURES: begin
            if (xfer) begin
               feat_load = 1'b1;
               if (last_byte) begin
                  state_d = ST_LABEL;
               end
            end
         end
         ST_LABEL: begin
            if (xfer) begin
               wr_label_d = ld.in_byte[LABEL_W-1:0];
               wr_addr_d  = sample_cnt_q;
               if (label_out_of_range(ld.in_byte)) begin
                  label_err_d = 1'b1;
               end
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // The last sample parks the counter instead of wrapping it
            if (sample_cnt_q == LAST_ADDR) begin
               state_d     = ST_DONE;
               load_done_d = 1'b1;
            end else begin
               sample_cnt_d = sample_cnt_q + ADDR_W'(1);
               state_d      = ST_FEATURES;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; status outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sample_cnt_q <= '0;
         wr_addr_q    <= '0;
         wr_label_q   <= '0;
         label_err_q  <= 1'b0;
         load_done_q  <= 1'b0;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         wr_addr_q    <= wr_addr_d;
         wr_label_q   <= wr_label_d;
         label_err_q  <= label_err_d;
         load_done_q  <= load_done_d;
         in_ready_q   <= (state_d == ST_FEATURES) || (state_d == ST_LABEL);
         wr_en_q      <= (state_d == ST_WRITE);
         busy_q       <= (state_d == ST_FEATURES) || (state_d == ST_LABEL) ||
                         (state_d == ST_WRITE);
      end
   end

   assign ld.in_ready  = in_ready_q;
   assign ld.wr_en     = wr_en_q;
   assign ld.wr_addr   = wr_addr_q;
   assign ld.wr_data   = feat_data;
   assign ld.wr_label  = wr_label_q;
   assign ld.busy      = busy_q;
   assign ld.load_done = load_done_q;
   assign ld.label_err = label_err_q;

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench: a 2-sample loader for protocol corners and a default 750-sample loader for a full run.
// Inputs driven and outputs sampled on the falling clock edge.
// Byte pushes wait for in_ready with a bounded cycle budget.
module tb_sample_loader;
   import sample_loader_pkg::*;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   stall_cycles;

   sample_loader_if if_s ();
   sample_loader_if if_f ();

   sample_loader #(.NUM_SAMPLES(2)) u_small (.clk(clk), .rst(rst), .ld(if_s));
   sample_loader                    u_full  (.clk(clk), .rst(rst), .ld(if_f));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write log of the small loader
   logic [ADDR_W-1:0]  wa_q[$];
   logic [FEAT_W-1:0]  wd_q[$];
   logic [LABEL_W-1:0] wl_q[$];
   always @(negedge clk) begin
      if (if_s.wr_en === 1'b1) begin
         wa_q.push_back(if_s.wr_addr);
         wd_q.push_back(if_s.wr_data);
         wl_q.push_back(if_s.wr_label);
      end
   end

   // Write tally of the full-size loader
   int                f_wr_cnt;
   logic [ADDR_W-1:0] f_last_addr;
   always @(negedge clk) begin
      if (if_f.wr_en === 1'b1) begin
         f_wr_cnt++;
         f_last_addr = if_f.wr_addr;
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit sel, input logic [7:0] b);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      if (sel) begin if_f.in_byte = b; if_f.in_valid = 1'b1; end
      else     begin if_s.in_byte = b; if_s.in_valid = 1'b1; end
      while (!acc && n < 100) begin
         acc = sel ? if_f.in_ready : if_s.in_ready;
         @(negedge clk);
         if (!acc) begin n++; stall_cycles++; end
      end
      if (!acc) chk("push_timeout", {511'b0, acc}, 512'd1);
      if (sel) if_f.in_valid = 1'b0;
      else     if_s.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      if_s.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) if_f.start = 1'b1; else if_s.start = 1'b1;
      @(negedge clk);
      if (sel) if_f.start = 1'b0; else if_s.start = 1'b0;
   endtask

   logic [FEAT_W-1:0] exp0, exp_ff, exp1b, exp55;

   initial begin
      vectors = 0; miscompares = 0; stall_cycles = 0; f_wr_cnt = 0; f_last_addr = '0;
      rst = 1'b1;
      if_s.start = 1'b0; if_s.in_valid = 1'b0; if_s.in_byte = 8'h00;
      if_f.start = 1'b0; if_f.in_valid = 1'b0; if_f.in_byte = 8'h00;
      for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) begin
         exp0[8*k +: 8]  = 8'(k);
         exp_ff[8*k +: 8] = 8'hFF;
         exp1b[8*k +: 8] = 8'(8'h80 + k);
         exp55[8*k +: 8] = 8'h55;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  if_s.in_ready,  0);
      chk("rst_wr_en",     if_s.wr_en,     0);
      chk("rst_busy",      if_s.busy,      0);
      chk("rst_load_done", if_s.load_done, 0);
      chk("rst_label_err", if_s.label_err, 0);
      chk("rst_wr_addr",   if_s.wr_addr,   0);
      chk("rst_wr_data",   if_s.wr_data,   0);
      chk("rst_wr_label",  if_s.wr_label,  0);

      // rst and start together: rst wins
      if_s.start = 1'b1;
      @(negedge clk);
      if_s.start = 1'b0;
      rst = 1'b0;
      chk("rst_beats_start_busy", if_s.busy, 0);
      @(negedge clk);
      chk("rst_beats_start_idle", if_s.in_ready, 0);

      // Two back-to-back samples
      pulse_start(0);
      chk("start_in_ready", if_s.in_ready, 1);
      chk("start_busy",     if_s.busy,     1);
      stall_cycles = 0;
      for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) push(0, 8'(k));
      push(0, 8'h07);
      chk("s0_wr_en",    if_s.wr_en,    1);
      chk("s0_wr_addr",  if_s.wr_addr,  0);
      for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) push(0, 8'hFF);
      push(0, 8'h03);
      chk("s1_wr_en",     if_s.wr_en,     1);
      chk("s1_wr_addr",   if_s.wr_addr,   1);
      chk("s1_wr_label",  if_s.wr_label,  3);
      chk("s1_load_done_early", if_s.load_done, 0);
      chk("b2b_stalls",   stall_cycles,   1);
      @(negedge clk);
      chk("done_load_done", if_s.load_done, 1);
      chk("done_wr_en",     if_s.wr_en,     0);
      chk("done_busy",      if_s.busy,      0);
      chk("done_in_ready",  if_s.in_ready,  0);
      chk("done_wr_addr",   if_s.wr_addr,   1);
      chk("done_label_err", if_s.label_err, 0);
      #1;
      chk("b2b_writes",  wa_q.size(), 2);
      chk("b2b_addr0",   wa_q[0], 0);
      chk("b2b_data0",   wd_q[0], exp0);
      chk("b2b_label0",  wl_q[0], 7);
      chk("b2b_addr1",   wa_q[1], 1);
      chk("b2b_data1",   wd_q[1], exp_ff);
      chk("b2b_label1",  wl_q[1], 3);
      wa_q.delete(); wd_q.delete(); wl_q.delete();

      // Restart from DONE, gapped sample 0 with a bad label, start ignored mid-sample
      pulse_start(0);
      chk("restart_load_done", if_s.load_done, 0);
      chk("restart_busy",      if_s.busy,      1);
      for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) begin
         idle($urandom_range(0, 2));
         if (k == 20) begin
            idle(4);
            chk("stall_in_ready", if_s.in_ready, 1);
            chk("stall_wr_en",    if_s.wr_en,    0);
         end
         push(0, 8'(k));
      end
      idle(2);
      chk("gap_label_wait_wr_en", if_s.wr_en, 0);
      push(0, 8'h1A);
      chk("bad_wr_en",     if_s.wr_en,     1);
      chk("bad_wr_addr",   if_s.wr_addr,   0);
      chk("bad_wr_label",  if_s.wr_label,  4'hA);
      chk("bad_label_err", if_s.label_err, 1);
      for (int k = 0; k < 5; k++) push(0, 8'(8'h80 + k));
      pulse_start(0);
      chk("midrun_start_busy",     if_s.busy,      1);
      chk("midrun_start_in_ready", if_s.in_ready,  1);
      for (int k = 5; k < DEF_BYTES_PER_SAMPLE; k++) push(0, 8'(8'h80 + k));
      push(0, 8'h05);
      chk("midrun_wr_en",   if_s.wr_en,   1);
      chk("midrun_wr_addr", if_s.wr_addr, 1);
      #1;
      chk("gap_writes", wd_q.size(), 2);
      chk("gap_data0",  wd_q[0], exp0);
      chk("gap_data1",  wd_q[1], exp1b);
      @(negedge clk);
      chk("err_done_load_done", if_s.load_done, 1);
      chk("err_sticky_done",    if_s.label_err, 1);
      pulse_start(0);
      chk("err_clear_on_start", if_s.label_err, 0);
      wa_q.delete(); wd_q.delete(); wl_q.delete();

      // Reset mid-run after byte 30 of sample 1
      for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) push(0, 8'(k));
      push(0, 8'h02);
      for (int k = 0; k <= 30; k++) push(0, 8'hC3);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready",  if_s.in_ready,  0);
      chk("mid_rst_wr_en",     if_s.wr_en,     0);
      chk("mid_rst_busy",      if_s.busy,      0);
      chk("mid_rst_load_done", if_s.load_done, 0);
      chk("mid_rst_label_err", if_s.label_err, 0);
      chk("mid_rst_wr_addr",   if_s.wr_addr,   0);
      chk("mid_rst_wr_data",   if_s.wr_data,   0);
      chk("mid_rst_wr_label",  if_s.wr_label,  0);
      rst = 1'b0;
      #1;
      chk("mid_rst_writes", wa_q.size(), 1);
      pulse_start(0);
      for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) push(0, 8'h55);
      push(0, 8'h01);
      chk("fresh_wr_en",    if_s.wr_en,    1);
      chk("fresh_wr_addr",  if_s.wr_addr,  0);
      chk("fresh_wr_label", if_s.wr_label, 1);
      #1;
      chk("fresh_writes", wd_q.size(), 2);
      chk("fresh_data",   wd_q[1], exp55);

      // Full default-size run, then hold in_valid high
      pulse_start(1);
      for (int s = 0; s < 750; s++) begin
         for (int k = 0; k < DEF_BYTES_PER_SAMPLE; k++) push(1, 8'(k) ^ 8'(s));
         push(1, 8'(s % 10));
      end
      if_f.in_valid = 1'b1;
      if_f.in_byte  = 8'h00;
      repeat (200) @(negedge clk);
      if_f.in_valid = 1'b0;
      #1;
      chk("full_wr_count",  f_wr_cnt,       750);
      chk("full_last_addr", f_last_addr,    749);
      chk("full_wr_addr",   if_f.wr_addr,   749);
      chk("full_load_done", if_f.load_done, 1);
      chk("full_in_ready",  if_f.in_ready,  0);
      chk("full_label_err", if_f.label_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
